// File: rtl/uart_tx_fifo_sequencer_if.sv
// FIFO-side and transmitter-side handshake of the UART TX sequencer.
// The master modport is the sequencer; the slave modport is the FIFO/transmitter pair.
interface uart_tx_fifo_sequencer_if;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_read;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_done;

    modport master (
        input  fifo_empty, fifo_data, tx_done,
        output fifo_read, tx_data, tx_start
    );

    modport slave (
        output fifo_empty, fifo_data, tx_done,
        input  fifo_read, tx_data, tx_start
    );
endinterface

// File: rtl/uart_tx_fifo_sequencer.sv
// Pops bytes from the TX FIFO, hands each to the UART transmitter with a start
// strobe, waits for done, then inserts a programmable gap; counts bytes and flags timeouts.
module uart_tx_fifo_sequencer #(
    parameter int GAP_WIDTH   = 8,
    parameter int TIMEOUT     = 65535,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [GAP_WIDTH-1:0]   gap_cycles,
    input  logic                   clear_error,
    uart_tx_fifo_sequencer_if.master tx_if,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] byte_count,
    output logic                   timeout_error
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    // Timeout fires on the cycle the counter would step to TIMEOUT.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LATCH,
        START,
        WAIT_DONE,
        GAP
    } state_t;

    state_t                state;
    logic [GAP_WIDTH-1:0]  gap_cnt;
    logic [TO_W-1:0]       to_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            tx_if.fifo_read <= 1'b0;
            tx_if.tx_start  <= 1'b0;
            tx_if.tx_data   <= 8'h00;
            busy            <= 1'b0;
            byte_count      <= '0;
            timeout_error   <= 1'b0;
            gap_cnt         <= '0;
            to_cnt          <= '0;
        end else begin
            tx_if.fifo_read <= 1'b0;
            tx_if.tx_start  <= 1'b0;
            // A timeout in the same cycle overrides the clear below.
            if (clear_error) begin
                timeout_error <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (enable && !tx_if.fifo_empty) begin
                        state           <= POP;
                        tx_if.fifo_read <= 1'b1;
                        busy            <= 1'b1;
                    end
                end
                POP: begin
                    state <= LATCH;
                end
                LATCH: begin
                    tx_if.tx_data  <= tx_if.fifo_data;
                    tx_if.tx_start <= 1'b1;
                    state          <= START;
                end
                START: begin
                    to_cnt <= '0;
                    state  <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (tx_if.tx_done) begin
                        byte_count <= byte_count + COUNT_WIDTH'(1);
                        if (gap_cycles == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cycles;
                            state   <= GAP;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        timeout_error <= 1'b1;
                        state         <= IDLE;
                        busy          <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - GAP_WIDTH'(1);
                    if (gap_cnt <= GAP_WIDTH'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_sequencer.sv
// Bench for uart_tx_fifo_sequencer: vector table, directed corner sequences and a
// randomized run against a transaction-level model of the FIFO and transmitter.
module tb_uart_tx_fifo_sequencer;
    localparam int TIMEOUT = 16;
    localparam int CW      = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic [7:0]    gap_cycles;
    logic          clear_error;
    logic          busy;
    logic [CW-1:0] byte_count;
    logic          timeout_error;

    uart_tx_fifo_sequencer_if bus ();

    uart_tx_fifo_sequencer #(
        .GAP_WIDTH  (8),
        .TIMEOUT    (TIMEOUT),
        .COUNT_WIDTH(CW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .gap_cycles   (gap_cycles),
        .clear_error  (clear_error),
        .tx_if        (bus),
        .busy         (busy),
        .byte_count   (byte_count),
        .timeout_error(timeout_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       en;
        logic       push;
        logic [7:0] pbyte;
        logic       done;
        logic       clr;
        logic       exp_rd;
        logic       exp_st;
        logic       exp_busy;
        logic [7:0] exp_data;
        int         exp_cnt;
    } vec_t;

    vec_t tbl[9];

    bit [7:0] q[$];
    bit [7:0] exp_q[$];
    int rd_cyc[$];
    int st_cyc[$];
    int dn_cyc[$];
    int cyc, acc, start_cyc, last_dn, last_gap;
    bit waiting, rd_seen, auto_on, dly_rand, gap_rand;
    int auto_wait, auto_dly, fixed_gap;
    int pass_cnt, chk_cnt;

    task automatic chk(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk_ge(input string name, input int act, input int lo);
        chk_cnt++;
        if (act >= lo) pass_cnt++;
        else $display("FAIL %s: got %0d, expected at least %0d", name, act, lo);
    endtask

    task automatic push_byte(input logic [7:0] b);
        q.push_back(b);
        exp_q.push_back(b);
        bus.fifo_empty = 1'b0;
    endtask

    // Advance one clock; update FIFO/transmitter models and check transaction rules.
    task automatic tick();
        logic       pd;
        logic [7:0] pg;
        @(posedge clock);
        pd = bus.tx_done;
        pg = gap_cycles;
        #1;
        cyc++;
        bus.tx_done = 1'b0;
        clear_error = 1'b0;
        if (rd_seen && q.size() != 0) bus.fifo_data = q.pop_front();
        rd_seen = bus.fifo_read;
        bus.fifo_empty = (q.size() == 0);
        if (pd && waiting && (cyc - 1 - start_cyc) <= TIMEOUT) begin
            acc++;
            waiting = 1'b0;
            dn_cyc.push_back(cyc - 1);
            last_dn  = cyc - 1;
            last_gap = int'(pg);
        end
        if (waiting && (cyc - start_cyc) > TIMEOUT) waiting = 1'b0;
        chk("byte_count", int'(byte_count), acc % (1 << CW));
        if (bus.fifo_read) begin
            chk_ge("read_nonempty", q.size(), 1);
            if (last_dn >= 0) chk_ge("read_after_gap", cyc, last_dn + last_gap + 2);
            rd_cyc.push_back(cyc);
        end
        if (auto_on && auto_wait > 0) begin
            auto_wait--;
            if (auto_wait == 0) begin
                bus.tx_done = 1'b1;
                gap_cycles  = gap_rand ? 8'($urandom_range(0, 5)) : 8'(fixed_gap);
            end
        end
        if (bus.tx_start) begin
            if (exp_q.size() == 0) chk("start_without_byte", 0, 1);
            else chk("tx_data", int'(bus.tx_data), int'(exp_q.pop_front()));
            waiting   = 1'b1;
            start_cyc = cyc;
            st_cyc.push_back(cyc);
            if (auto_on) auto_wait = dly_rand ? int'($urandom_range(1, 12)) : auto_dly;
        end
        if (waiting || bus.fifo_read || bus.tx_start) chk("busy_active", int'(busy), 1);
    endtask

    task automatic wait_start(input int bound);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.tx_start && n < bound);
        if (!bus.tx_start) chk("start_within_bound", 0, 1);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        bit idle;
        n = 0;
        do begin
            tick();
            n++;
            idle = !busy && q.size() == 0 && !waiting && auto_wait == 0;
        end while (!idle && n < bound);
        chk("idle_within_bound", int'(idle), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, nrd, t;
        pass_cnt = 0; chk_cnt = 0; cyc = 0; acc = 0; last_dn = -1; last_gap = 0;
        waiting = 0; rd_seen = 0; auto_on = 0; dly_rand = 0; gap_rand = 0;
        auto_wait = 0; auto_dly = 3; fixed_gap = 0; start_cyc = 0;
        reset = 1'b0; enable = 1'b0; gap_cycles = 8'd0; clear_error = 1'b0;
        bus.fifo_empty = 1'b1; bus.fifo_data = 8'h00; bus.tx_done = 1'b0;

        //                en push byte   done clr  rd st busy data  cnt
        tbl[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0};
        tbl[1] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0};
        tbl[2] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0};
        tbl[3] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0};
        tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0};
        tbl[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 0};
        tbl[6] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0};
        tbl[7] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 0};
        tbl[8] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 0};

        repeat (3) @(posedge clock);
        #1;
        chk("rst_fifo_read", int'(bus.fifo_read), 0);
        chk("rst_tx_start", int'(bus.tx_start), 0);
        chk("rst_tx_data", int'(bus.tx_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_byte_count", int'(byte_count), 0);
        chk("rst_timeout_error", int'(timeout_error), 0);
        @(negedge clock);
        reset = 1'b1;

        // Idle behaviour, spurious done, then first byte 8'hA5
        for (int i = 0; i < 9; i++) begin
            enable = tbl[i].en;
            if (tbl[i].push) push_byte(tbl[i].pbyte);
            bus.tx_done = tbl[i].done;
            clear_error = tbl[i].clr;
            tick();
            chk($sformatf("vec%0d_fifo_read", i), int'(bus.fifo_read), int'(tbl[i].exp_rd));
            chk($sformatf("vec%0d_tx_start", i), int'(bus.tx_start), int'(tbl[i].exp_st));
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].exp_busy));
            chk($sformatf("vec%0d_tx_data", i), int'(bus.tx_data), int'(tbl[i].exp_data));
            chk($sformatf("vec%0d_byte_count", i), int'(byte_count), tbl[i].exp_cnt);
        end
        repeat (9) tick();
        bus.tx_done = 1'b1;
        gap_cycles  = 8'd0;
        tick();
        chk("a_byte_count", int'(byte_count), 1);
        chk("a_busy_after_done", int'(busy), 0);
        tick();
        chk("a_no_second_read", int'(bus.fifo_read), 0);

        // Three bytes with gap 4: exact read/start spacing and order
        rd_cyc.delete(); st_cyc.delete(); dn_cyc.delete();
        auto_on = 1; dly_rand = 0; gap_rand = 0; auto_dly = 3; fixed_gap = 4;
        push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
        wait_idle(200);
        chk("b_starts", st_cyc.size(), 3);
        chk("b_byte_count", int'(byte_count), 4);
        if (st_cyc.size() == 3 && rd_cyc.size() == 3 && dn_cyc.size() == 3) begin
            for (int i = 0; i < 2; i++) begin
                chk("b_read_after_done", rd_cyc[i+1], dn_cyc[i] + 6);
                chk("b_start_after_read", st_cyc[i+1], rd_cyc[i+1] + 2);
                chk_ge("b_start_spacing", st_cyc[i+1] - dn_cyc[i], 6);
            end
        end

        // enable dropped just after tx_start with a byte still queued
        base = acc; fixed_gap = 2;
        push_byte(8'h11); push_byte(8'h22);
        wait_start(20);
        tick();
        enable = 1'b0;
        nrd = rd_cyc.size();
        repeat (30) tick();
        chk("c_count_one", int'(byte_count), (base + 1) % (1 << CW));
        chk("c_no_read_disabled", rd_cyc.size(), nrd);
        chk("c_idle", int'(busy), 0);
        chk("c_byte_still_queued", q.size(), 1);
        enable = 1'b1;
        wait_start(20);
        wait_idle(50);
        chk("c_count_two", int'(byte_count), (base + 2) % (1 << CW));

        // Spurious tx_done during GAP
        auto_on = 0; base = acc;
        push_byte(8'h5A);
        wait_start(20);
        nrd = rd_cyc.size();
        repeat (2) tick();
        bus.tx_done = 1'b1; gap_cycles = 8'd5;
        tick();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b1;
        tick();
        chk("e_count_gap_done", int'(byte_count), (base + 1) % (1 << CW));
        wait_idle(20);
        chk("e_no_read", rd_cyc.size(), nrd);

        // Timeout after exactly TIMEOUT cycles in WAIT_DONE, then clear
        base = acc;
        push_byte(8'h77);
        wait_start(20);
        t = cyc;
        while (cyc < t + 16) tick();
        chk("d_no_err_early", int'(timeout_error), 0);
        chk("d_busy_early", int'(busy), 1);
        tick();
        chk("d_err_set", int'(timeout_error), 1);
        chk("d_idle_after_to", int'(busy), 0);
        chk("d_count_unchanged", int'(byte_count), base % (1 << CW));
        clear_error = 1'b1;
        tick();
        chk("d_err_cleared", int'(timeout_error), 0);

        // tx_done on the last allowed cycle beats the timeout
        base = acc;
        push_byte(8'h78);
        wait_start(20);
        t = cyc;
        while (cyc < t + 16) tick();
        bus.tx_done = 1'b1; gap_cycles = 8'd0;
        tick();
        chk("d_done_wins_err", int'(timeout_error), 0);
        chk("d_done_wins_count", int'(byte_count), (base + 1) % (1 << CW));

        // Randomized traffic with enable toggling
        auto_on = 1; dly_rand = 1; gap_rand = 1;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 3) == 0 && q.size() < 6) push_byte(8'($urandom));
            if ($urandom_range(0, 19) == 0) enable = ~enable;
            tick();
        end
        enable = 1'b1;
        wait_idle(400);
        chk("r_no_timeout", int'(timeout_error), 0);
        chk("r_all_sent", exp_q.size(), 0);
        chk_ge("r_wrapped", acc, 1 << CW);

        // Asynchronous reset while waiting for done
        auto_on = 0;
        push_byte(8'h3C);
        wait_start(20);
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("g_busy", int'(busy), 0);
        chk("g_fifo_read", int'(bus.fifo_read), 0);
        chk("g_tx_start", int'(bus.tx_start), 0);
        chk("g_tx_data", int'(bus.tx_data), 0);
        chk("g_byte_count", int'(byte_count), 0);
        chk("g_timeout_error", int'(timeout_error), 0);
        acc = 0; waiting = 0; last_dn = -1; rd_seen = 0;
        tick();
        @(negedge clock);
        reset = 1'b1;
        nrd = rd_cyc.size();
        repeat (5) tick();
        chk("g_stays_idle", int'(busy), 0);
        chk("g_no_read", rd_cyc.size(), nrd);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
